alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the HRM CPU datapath. It extends the single-cycle add/sub/bump/flag ALU with WIDTH-generic operands, iterative signed multiply, divide and modulo, an overflow flag, and a start/done handshake. The control unit stalls on `busy` while a long operation runs. It sits between the accumulator register (`inR`) and the memory data path (`inM`), and its result feeds back into the accumulator mux.

## Interface
- `WIDTH`, default 8: operand and result width in bits, two's complement, WIDTH ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `aluCtl`  in  3  opcode: 0 ADD (R+M), 1 SUB (R−M), 2 BUMP+ (M+1), 3 BUMP− (M−1), 4 MUL (R×M), 5 DIV (R÷M), 6 MOD (R rem M), 7 PASS (R).
- `inR`  in  WIDTH  signed accumulator operand.
- `inM`  in  WIDTH  signed memory operand.
- `busy`  out  1  high while a multi-cycle operation is in progress.
- `done`  out  1  one-cycle pulse; result and flags are valid from this cycle onward.
- `aluOut`  out  WIDTH  registered signed result.
- `flagZ`  out  1  `aluOut` == 0.
- `flagN`  out  1  `aluOut[WIDTH-1]`.
- `flagV`  out  1  signed overflow; result truncated to WIDTH.
- `flagE`  out  1  divide-by-zero error.

## Operation
- States are IDLE, MUL, DIV and FIX.
  - Ops 0–3 and 7, and DIV/MOD with `inM`=0, complete directly from IDLE.
  - MUL goes IDLE→MUL→IDLE.
  - DIV/MOD go IDLE→DIV→FIX→IDLE.
- Operands and opcode are latched at the accepted `start` edge. Later changes to `inR`, `inM` or `aluCtl` have no effect on that operation.
- ADD, SUB, BUMP±: wrap modulo 2^WIDTH. `flagV` is set on a signed carry-out mismatch (e.g. 100+100, −128−1).
- MUL: shift-add on magnitudes, then sign correction; one partial product per cycle.
  - `aluOut` is the low WIDTH bits of the exact product.
  - `flagV` = 1 when the exact product lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- DIV/MOD: restoring division on magnitudes, one quotient bit per cycle. FIX applies the signs.
  - The quotient truncates toward zero.
  - The remainder takes the sign of `inR`.
  - Min÷(−1): quotient = min (wraps), `flagV`=1; MOD result = 0, `flagV`=0.
- Divide by zero: `aluOut`=0, `flagE`=1, `flagZ`=1, `flagV`=0. Completes in one cycle.
- `flagE` is 0 for every other completion.
- Flags are computed from the final registered result. They update only at `done`, together with `aluOut`, and hold until the next completion.
- `start` while `busy`=1 is ignored and is not queued.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `aluOut`=0, `flagZ`=1, `flagN`=0, `flagV`=0, `flagE`=0.
- Latency L is the number of rising edges from the edge that accepts `start` to the edge that asserts `done`:
  - single-cycle ops and divide-by-zero: L=1;
  - MUL: L=WIDTH;
  - DIV/MOD: L=WIDTH+1.
- `busy` rises on the edge after an accepted multi-cycle `start` and falls on the same edge that raises `done`. `busy` never rises for single-cycle ops.
- Back-to-back: `start` may be asserted in the cycle in which `done` is high. It is accepted on the next edge, so there is zero bubble.
- `rst` asserted mid-operation aborts immediately. All outputs return to their reset values, and no `done` is produced for the aborted op.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams OP_ADD … OP_PASS (3-bit);
  - state encoding ST_IDLE, ST_MUL, ST_DIV, ST_FIX.
- Sub-module `alu_divider`: iterative unsigned restoring divider with WIDTH-bit magnitude inputs, `load`/`step` controls, and quotient/remainder outputs. The top-level state machine drives it.
- The multiply datapath and sign handling stay inline in `alu_mc`.

## Test plan
- ADD: R=−3, M=5 → `done` 1 cycle after `start`, `aluOut`=2, Z=0, N=0, V=0. SUB with the same operands → −8, N=1.
- Overflow and bump: ADD 100+100 → −56, V=1, N=1. BUMP− with M=−128 → 127, V=1. PASS R=0 → Z=1.
- MUL: −3×5 → −15 with `done` exactly 8 cycles after `start` and `busy` high for 7 cycles. 16×16 → 0, Z=1, V=1.
- DIV/MOD: −7÷2 → −3; −7 mod 2 → −1; each 9 cycles. −128÷−1 → −128, V=1. 5÷0 → 0, E=1, 1 cycle.
- Handshake: `start` pulsed during a MUL is ignored; `start` held high in the `done` cycle starts the next op with no bubble. Operands changed during `busy` do not alter the result.
- Reset: assert `rst` at cycle 3 of a DIV → outputs at reset values immediately, no `done`. A fresh ADD afterwards completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared opcode and state encodings for the multi-cycle ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // 3-bit ALU opcodes as presented on aluCtl
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_BUMPP = 3'd2;
    localparam logic [2:0] OP_BUMPM = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_MOD   = 3'd6;
    localparam logic [2:0] OP_PASS  = 3'd7;

    // Control state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_if
//  Brief    : Request/result bundle between the control unit and alu_mc.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [2:0]       aluCtl;
    logic [WIDTH-1:0] inR;
    logic [WIDTH-1:0] inM;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] aluOut;
    logic             flagZ;
    logic             flagN;
    logic             flagV;
    logic             flagE;

    // Requester side (control unit / testbench)
    modport master (
        output start, aluCtl, inR, inM,
        input  busy, done, aluOut, flagZ, flagN, flagV, flagE
    );

    // ALU side
    modport slave (
        input  start, aluCtl, inR, inM,
        output busy, done, aluOut, flagZ, flagN, flagV, flagE
    );
endinterface
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
//  Module   : alu_divider
//  Brief    : Iterative unsigned restoring divider, one quotient bit per
//             load or step. load consumes the operands and also produces the
//             first quotient bit, so WIDTH bits need load + (WIDTH-1) steps.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] src_quo, src_rem, src_dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, shift the quotient bit in.
    always_comb begin
        src_quo = load ? dividend : quo_q;
        src_rem = load ? '0       : rem_q;
        src_dvs = load ? divisor  : dvs_q;
        trial   = {src_rem, src_quo[WIDTH-1]};
        diff    = trial - {1'b0, src_dvs};
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        if (load || step) begin
            dvs_d = src_dvs;
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divider working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Brief    : Parametrised multi-cycle ALU: single-cycle add/sub/bump/pass,
//             iterative signed multiply, divide and modulo, start/done
//             handshake with busy stall, registered result and flags.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    alu_mc_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             qneg_q, qneg_d;     // sign of product / quotient
    logic             rneg_q, rneg_d;     // sign of dividend (remainder sign)
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_e_q, flag_e_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_r, mag_m;
    logic [WIDTH-1:0] quick_res;
    logic             quick_v;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    prod;
    logic             div_load, div_step;
    logic [WIDTH-1:0] div_quo, div_rem;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    assign mag_r = bus.inR[WIDTH-1] ? ('0 - bus.inR) : bus.inR;
    assign mag_m = bus.inM[WIDTH-1] ? ('0 - bus.inM) : bus.inM;

    // Single-cycle results and their signed-overflow flags
    always_comb begin
        quick_res = bus.inR;
        quick_v   = 1'b0;
        case (bus.aluCtl)
            OP_ADD: begin
                quick_res = bus.inR + bus.inM;
                quick_v   = (bus.inR[WIDTH-1] == bus.inM[WIDTH-1]) &&
                            (quick_res[WIDTH-1] != bus.inR[WIDTH-1]);
            end
            OP_SUB: begin
                quick_res = bus.inR - bus.inM;
                quick_v   = (bus.inR[WIDTH-1] != bus.inM[WIDTH-1]) &&
                            (quick_res[WIDTH-1] != bus.inR[WIDTH-1]);
            end
            OP_BUMPP: begin
                quick_res = bus.inM + 1'b1;
                quick_v   = !bus.inM[WIDTH-1] && quick_res[WIDTH-1];
            end
            OP_BUMPM: begin
                quick_res = bus.inM - 1'b1;
                quick_v   = bus.inM[WIDTH-1] && !quick_res[WIDTH-1];
            end
            default: begin
                quick_res = bus.inR;
                quick_v   = 1'b0;
            end
        endcase
    end

    // Control FSM next-state, multiply datapath and result/flag update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        alu_out_d = alu_out_q;
        flag_v_d  = flag_v_q;
        flag_e_d  = flag_e_q;
        done_d    = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod      = qneg_q ? ('0 - acc_next) : acc_next;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.aluCtl;
                    qneg_d = bus.inR[WIDTH-1] ^ bus.inM[WIDTH-1];
                    rneg_d = bus.inR[WIDTH-1];
                    cnt_d  = CW'(1);
                    case (bus.aluCtl)
                        OP_MUL: begin
                            // first partial product is folded into the accept edge
                            acc_d    = mag_m[0] ? {{WIDTH{1'b0}}, mag_r} : '0;
                            mcand_d  = {{(WIDTH-1){1'b0}}, mag_r, 1'b0};
                            mplier_d = mag_m >> 1;
                            state_d  = ST_MUL;
                        end
                        OP_DIV, OP_MOD: begin
                            if (bus.inM == '0) begin
                                alu_out_d = '0;
                                flag_v_d  = 1'b0;
                                flag_e_d  = 1'b1;
                                done_d    = 1'b1;
                            end else begin
                                div_load = 1'b1;
                                state_d  = ST_DIV;
                            end
                        end
                        default: begin
                            alu_out_d = quick_res;
                            flag_v_d  = quick_v;
                            flag_e_d  = 1'b0;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // overflow unless the upper WIDTH+1 bits are a pure sign extension
                    alu_out_d = prod[WIDTH-1:0];
                    flag_v_d  = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
                    flag_e_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (op_q == OP_DIV) begin
                    // a positive quotient of magnitude 2^(WIDTH-1) only arises from min / -1
                    alu_out_d = qneg_q ? ('0 - div_quo) : div_quo;
                    flag_v_d  = !qneg_q && div_quo[WIDTH-1];
                end else begin
                    alu_out_d = rneg_q ? ('0 - div_rem) : div_rem;
                    flag_v_d  = 1'b0;
                end
                flag_e_d = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            alu_out_q <= '0;
            flag_v_q  <= 1'b0;
            flag_e_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            alu_out_q <= alu_out_d;
            flag_v_q  <= flag_v_d;
            flag_e_q  <= flag_e_d;
            done_q    <= done_d;
        end
    end

    alu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_r),
        .divisor   (mag_m),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.aluOut = alu_out_q;
    assign bus.flagZ  = (alu_out_q == '0);
    assign bus.flagN  = alu_out_q[WIDTH-1];
    assign bus.flagV  = flag_v_q;
    assign bus.flagE  = flag_e_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Brief    : Self-checking bench for alu_mc: directed corner cases plus
//             randomized operations against an integer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap to W bits and range-check
    function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] r,
                                    input logic [W-1:0] m, output logic [W-1:0] res,
                                    output logic v, output logic e, output int lat);
        longint sr, sm, x, lo, hi;
        sr  = longint'($signed(r));
        sm  = longint'($signed(m));
        lo  = -(longint'(1) <<< (W - 1));
        hi  = (longint'(1) <<< (W - 1)) - 1;
        x   = 0;
        e   = 1'b0;
        lat = 1;
        case (op)
            3'd0: x = sr + sm;
            3'd1: x = sr - sm;
            3'd2: x = sm + 1;
            3'd3: x = sm - 1;
            3'd4: begin x = sr * sm; lat = W; end
            3'd5: if (sm == 0) e = 1'b1; else begin x = sr / sm; lat = W + 1; end
            3'd6: if (sm == 0) e = 1'b1; else begin x = sr % sm; lat = W + 1; end
            default: x = sr;
        endcase
        res = x[W-1:0];
        v   = (x < lo) || (x > hi);
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " busy"},   bus.busy,   0);
        check_eq({tag, " done"},   bus.done,   0);
        check_eq({tag, " aluOut"}, bus.aluOut, 0);
        check_eq({tag, " Z"},      bus.flagZ,  1);
        check_eq({tag, " N"},      bus.flagN,  0);
        check_eq({tag, " V"},      bus.flagV,  0);
        check_eq({tag, " E"},      bus.flagE,  0);
    endtask

    // Issue one op at the current negedge and wait for done. Returns at the
    // negedge where done is seen, so a following call starts with no bubble.
    // noisy: scramble inputs and pulse start while busy.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] r,
                          input logic [W-1:0] m, input bit noisy);
        logic [W-1:0] er;
        logic         ev, ee;
        int           el, lat, bcnt;
        string        t;
        ref_alu(op, r, m, er, ev, ee, el);
        t = $sformatf("op%0d r=%0d m=%0d", op, $signed(r), $signed(m));
        bus.start  = 1'b1;
        bus.aluCtl = op;
        bus.inR    = r;
        bus.inM    = m;
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            if (noisy) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.aluCtl = 3'($urandom_range(0, 7));
                bus.inR    = W'($urandom);
                bus.inM    = W'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check_eq({t, " latency"},   lat,        el);
        check_eq({t, " busy-cyc"},  bcnt,       (el > 1) ? el - 1 : 0);
        check_eq({t, " busy@done"}, bus.busy,   0);
        check_eq({t, " aluOut"},    bus.aluOut, er);
        check_eq({t, " V"},         bus.flagV,  ev);
        check_eq({t, " E"},         bus.flagE,  ee);
        check_eq({t, " Z"},         bus.flagZ,  (er == '0) ? 1 : 0);
        check_eq({t, " N"},         bus.flagN,  er[W-1]);
    endtask

    // Idle cycles: no done may appear and the result must hold
    task automatic idle(input int n);
        logic [W-1:0] hold;
        logic         hv, he;
        hold = bus.aluOut;
        hv   = bus.flagV;
        he   = bus.flagE;
        bus.start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_eq("idle done",   bus.done,   0);
            check_eq("idle aluOut", bus.aluOut, hold);
            check_eq("idle V",      bus.flagV,  hv);
            check_eq("idle E",      bus.flagE,  he);
        end
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] r, m;
        bit           seen;

        bus.start  = 1'b0;
        bus.aluCtl = 3'd0;
        bus.inR    = '0;
        bus.inM    = '0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("in-reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post-reset");

        // Directed corners; consecutive calls are back-to-back (start held in done cycle)
        run_op(OP_ADD,   W'(-3),   W'(5),    1'b0);
        run_op(OP_SUB,   W'(-3),   W'(5),    1'b0);
        run_op(OP_ADD,   W'(100),  W'(100),  1'b0);
        run_op(OP_BUMPM, W'(0),    W'(-128), 1'b0);
        run_op(OP_BUMPP, W'(0),    W'(127),  1'b0);
        run_op(OP_PASS,  W'(0),    W'(9),    1'b0);
        run_op(OP_MUL,   W'(-3),   W'(5),    1'b0);
        run_op(OP_MUL,   W'(16),   W'(16),   1'b0);
        run_op(OP_MUL,   W'(-128), W'(-128), 1'b0);
        run_op(OP_DIV,   W'(-7),   W'(2),    1'b0);
        run_op(OP_MOD,   W'(-7),   W'(2),    1'b0);
        run_op(OP_DIV,   W'(-128), W'(-1),   1'b0);
        run_op(OP_MOD,   W'(-128), W'(-1),   1'b0);
        run_op(OP_DIV,   W'(5),    W'(0),    1'b0);
        run_op(OP_MOD,   W'(-5),   W'(0),    1'b0);
        run_op(OP_DIV,   W'(127),  W'(-128), 1'b0);
        idle(2);

        // Start pulses and operand changes while busy must have no effect
        run_op(OP_MUL, W'(-3),  W'(5),  1'b1);
        idle(2);
        run_op(OP_DIV, W'(100), W'(-7), 1'b1);
        run_op(OP_MOD, W'(100), W'(-7), 1'b1);
        idle(1);

        // Abort a divide at cycle 3 with reset
        run_op(OP_ADD, W'(1), W'(1), 1'b0);
        bus.start  = 1'b1;
        bus.aluCtl = OP_DIV;
        bus.inR    = W'(100);
        bus.inM    = W'(7);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre-abort busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1 check_reset_vals("abort");
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check_eq("no done after abort", seen, 0);
        run_op(OP_ADD, W'(20), W'(22), 1'b0);
        idle(1);

        // Randomized operations with corner-biased operands
        repeat (200) begin
            op = 3'($urandom_range(0, 7));
            r  = W'($urandom);
            m  = W'($urandom);
            case ($urandom_range(0, 9))
                0: m = '0;
                1: begin r = {1'b1, {(W-1){1'b0}}}; m = '1; end
                2: r = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            run_op(op, r, m, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
